// File: rtl/queue_pkg.sv
// queue_pkg
// Shared constants and helpers for the parameterised queue.
//   DEF_DATA_W / DEF_DEPTH : default word width and capacity
//   ptr_w(depth)           : bits needed to address a depth-entry buffer
//   cnt_w(depth)           : bits needed to hold a count of 0..depth
package queue_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   // Pointer width never drops below one bit, even for the smallest buffer.
   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   // The count needs one extra state so that "full" (== depth) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/queue_ptr.sv
// queue_ptr
// Wrapping pointer counter for the circular buffer.
//   clk_10khz : clock, rising edge
//   reset     : asynchronous, active-high, forces ptr to 0
//   en        : advance the pointer by one on this edge
//   ptr       : current pointer, wraps DEPTH-1 -> 0
module queue_ptr #(
   parameter int PTR_W = 3,
   parameter int DEPTH = 8
) (
   input  logic             clk_10khz,
   input  logic             reset,
   input  logic             en,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   // Explicit wrap compare keeps the counter correct even if DEPTH is not
   // exactly 2**PTR_W.
   always_ff @(posedge clk_10khz or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (en) begin
         if (ptr == LAST) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/param_queue.sv
// param_queue
// Parameterised circular-buffer queue with occupancy and sticky error flags.
//   clk_10khz, reset        : clock and asynchronous active-high reset
//   data_in, enqueue_in     : word to store and its request
//   dequeue_in              : request to remove the head word
//   clear_flags             : clears sticky overflow/underflow
//   ack_in, deq_valid       : one-cycle pulses after an accepted enqueue/dequeue
//   data_out                : dequeued word (FWFT=0) or live head (FWFT=1)
//   len_out                 : current word count
//   full, empty, almost_full, almost_empty : occupancy flags from the count
//   overflow, underflow     : sticky error flags
module param_queue
   import queue_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AFULL_TH  = DEPTH - 1,
   parameter int AEMPTY_TH = 1,
   parameter int FWFT      = 0
) (
   input  logic                      clk_10khz,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      enqueue_in,
   input  logic                      dequeue_in,
   input  logic                      clear_flags,
   output logic                      ack_in,
   output logic                      deq_valid,
   output logic [DATA_W-1:0]         data_out,
   output logic [cnt_w(DEPTH)-1:0]   len_out,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              deq_acc;
   logic              enq_acc;

   // A dequeue needs something to remove. An enqueue into a full queue is
   // still fine if the head leaves on the same edge, but there is no bypass
   // at empty because the dequeue is never accepted there.
   always_comb begin
      deq_acc = dequeue_in && (count != '0);
      enq_acc = enqueue_in && ((count < DEPTH_C) || deq_acc);
   end

   queue_ptr #(.PTR_W(PW), .DEPTH(DEPTH)) u_wr_ptr (
      .clk_10khz (clk_10khz),
      .reset     (reset),
      .en        (enq_acc),
      .ptr       (wr_ptr)
   );

   queue_ptr #(.PTR_W(PW), .DEPTH(DEPTH)) u_rd_ptr (
      .clk_10khz (clk_10khz),
      .reset     (reset),
      .en        (deq_acc),
      .ptr       (rd_ptr)
   );

   // Storage is deliberately left out of reset; a reset empties the queue by
   // clearing the pointers and count, so stale contents are never visible.
   always_ff @(posedge clk_10khz) begin
      if (enq_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Count moves only when exactly one of enqueue/dequeue is accepted.
   always_ff @(posedge clk_10khz or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else begin
         case ({enq_acc, deq_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Handshake pulses and sticky error flags; a new error on the same edge as
   // clear_flags keeps the flag set.
   always_ff @(posedge clk_10khz or posedge reset) begin
      if (reset) begin
         ack_in    <= 1'b0;
         deq_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         ack_in    <= enq_acc;
         deq_valid <= deq_acc;
         if (enqueue_in && !enq_acc) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end
         if (dequeue_in && (count == '0)) begin
            underflow <= 1'b1;
         end else if (clear_flags) begin
            underflow <= 1'b0;
         end
      end
   end

   // Read side: either a registered copy of the word just dequeued, or the
   // live head word for first-word-fall-through.
   if (FWFT != 0) begin : g_fwft
      assign data_out = (count != '0) ? mem[rd_ptr] : '0;
   end else begin : g_reg
      always_ff @(posedge clk_10khz or posedge reset) begin
         if (reset) begin
            data_out <= '0;
         end else if (deq_acc) begin
            data_out <= mem[rd_ptr];
         end
      end
   end

   always_comb begin
      len_out      = count;
      full         = (count == DEPTH_C);
      empty        = (count == '0);
      almost_full  = (count >= AFULL_C);
      almost_empty = (count <= AEMPTY_C);
   end

endmodule

// File: tb/tb_param_queue.sv
// tb_param_queue
// Self-checking bench for param_queue: a registered-output instance and a
// first-word-fall-through instance share one stimulus stream and are both
// compared every cycle against a queue-based reference model, with directed
// literal checks along the way.
module tb_param_queue;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int AFULL  = DEPTH - 1;
   localparam int AEMPTY = 1;

   logic              clk_10khz = 1'b0;
   logic              reset = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              enqueue_in = 1'b0;
   logic              dequeue_in = 1'b0;
   logic              clear_flags = 1'b0;

   logic              ack_in, deq_valid, full, empty, almost_full, almost_empty;
   logic              overflow, underflow;
   logic [DATA_W-1:0] data_out;
   logic [3:0]        len_out;

   logic              f_ack_in, f_deq_valid, f_full, f_empty, f_almost_full;
   logic              f_almost_empty, f_overflow, f_underflow;
   logic [DATA_W-1:0] f_data_out;
   logic [3:0]        f_len_out;

   int n_checks = 0;
   int n_fail   = 0;
   bit model_live = 1'b0;

   // Reference model state
   logic [DATA_W-1:0] q[$];
   logic              exp_ack, exp_deqv, exp_ovf, exp_udf;
   logic [DATA_W-1:0] exp_data;

   // 10 kHz nominal clock, unitless period of 100
   always #50 clk_10khz = ~clk_10khz;

   param_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(0)) dut (
      .clk_10khz    (clk_10khz),
      .reset        (reset),
      .data_in      (data_in),
      .enqueue_in   (enqueue_in),
      .dequeue_in   (dequeue_in),
      .clear_flags  (clear_flags),
      .ack_in       (ack_in),
      .deq_valid    (deq_valid),
      .data_out     (data_out),
      .len_out      (len_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   param_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1)) dut_f (
      .clk_10khz    (clk_10khz),
      .reset        (reset),
      .data_in      (data_in),
      .enqueue_in   (enqueue_in),
      .dequeue_in   (dequeue_in),
      .clear_flags  (clear_flags),
      .ack_in       (f_ack_in),
      .deq_valid    (f_deq_valid),
      .data_out     (f_data_out),
      .len_out      (f_len_out),
      .full         (f_full),
      .empty        (f_empty),
      .almost_full  (f_almost_full),
      .almost_empty (f_almost_empty),
      .overflow     (f_overflow),
      .underflow    (f_underflow)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of requests, let the edge happen, and return at the
   // following falling edge with all requests released.
   task automatic applyStimulus(input logic enq, input logic deq,
                                input logic [DATA_W-1:0] d, input logic clr);
      enqueue_in  = enq;
      dequeue_in  = deq;
      data_in     = d;
      clear_flags = clr;
      @(posedge clk_10khz);
      @(negedge clk_10khz);
      enqueue_in  = 1'b0;
      dequeue_in  = 1'b0;
      clear_flags = 1'b0;
   endtask

   // Reference model: a plain word queue updated by the acceptance rules.
   initial begin
      exp_ack = 0; exp_deqv = 0; exp_ovf = 0; exp_udf = 0; exp_data = '0;
      forever begin
         @(posedge clk_10khz or posedge reset);
         if (reset) begin
            q.delete();
            exp_ack = 0; exp_deqv = 0; exp_ovf = 0; exp_udf = 0; exp_data = '0;
         end else begin
            automatic bit deq_ok = dequeue_in && (q.size() > 0);
            automatic bit enq_ok = enqueue_in && ((q.size() < DEPTH) || deq_ok);
            automatic bit ovf    = enqueue_in && !enq_ok;
            automatic bit udf    = dequeue_in && (q.size() == 0);
            if (deq_ok) exp_data = q.pop_front();
            if (enq_ok) q.push_back(data_in);
            exp_ack  = enq_ok;
            exp_deqv = deq_ok;
            if (ovf) exp_ovf = 1; else if (clear_flags) exp_ovf = 0;
            if (udf) exp_udf = 1; else if (clear_flags) exp_udf = 0;
         end
      end
   end

   // Every falling edge: compare both instances against the model.
   initial begin
      forever begin
         @(negedge clk_10khz);
         if (model_live) begin
            automatic int n = q.size();
            automatic logic [DATA_W-1:0] head = (n > 0) ? q[0] : '0;
            checkOutput("ack_in",       32'(ack_in),       32'(exp_ack));
            checkOutput("deq_valid",    32'(deq_valid),    32'(exp_deqv));
            checkOutput("data_out",     32'(data_out),     32'(exp_data));
            checkOutput("len_out",      32'(len_out),      32'(n));
            checkOutput("full",         32'(full),         32'(n == DEPTH));
            checkOutput("empty",        32'(empty),        32'(n == 0));
            checkOutput("almost_full",  32'(almost_full),  32'(n >= AFULL));
            checkOutput("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
            checkOutput("overflow",     32'(overflow),     32'(exp_ovf));
            checkOutput("underflow",    32'(underflow),    32'(exp_udf));
            checkOutput("fwft_data",    32'(f_data_out),   32'(head));
            checkOutput("fwft_len",     32'(f_len_out),    32'(n));
            checkOutput("fwft_ack",     32'(f_ack_in),     32'(exp_ack));
            checkOutput("fwft_deqv",    32'(f_deq_valid),  32'(exp_deqv));
            checkOutput("fwft_ovf",     32'(f_overflow),   32'(exp_ovf));
            checkOutput("fwft_udf",     32'(f_underflow),  32'(exp_udf));
            checkOutput("fwft_flags",   32'({f_full, f_empty, f_almost_full, f_almost_empty}),
                        32'({n == DEPTH, n == 0, n >= AFULL, n <= AEMPTY}));
         end
      end
   end

   // Directed scenarios with hand-computed expectations
   initial begin
      #1 reset = 1'b1;
      #1;
      model_live = 1'b1;
      checkOutput("rst_len",    32'(len_out), 32'd0);
      checkOutput("rst_empty",  32'(empty), 32'd1);
      checkOutput("rst_aempty", 32'(almost_empty), 32'd1);
      checkOutput("rst_full",   32'(full), 32'd0);
      checkOutput("rst_data",   32'(data_out), 32'd0);
      repeat (2) @(negedge clk_10khz);
      reset = 1'b0;

      // Fill 0x11..0x88
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b0, 8'(i * 8'h11), 1'b0);
         checkOutput("fill_ack", 32'(ack_in), 32'd1);
      end
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_len",  32'(len_out), 32'd8);

      // Ninth enqueue is rejected
      applyStimulus(1'b1, 1'b0, 8'h99, 1'b0);
      checkOutput("ovf_ack",  32'(ack_in), 32'd0);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("ovf_clear", 32'(overflow), 32'd0);

      // Drain in order, then underflow
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("drain_data", 32'(data_out), 32'(i * 8'h11));
         checkOutput("drain_dv",   32'(deq_valid), 32'd1);
      end
      checkOutput("drain_empty", 32'(empty), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("udf_flag", 32'(underflow), 32'd1);
      checkOutput("udf_dv",   32'(deq_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

      // Simultaneous enqueue + dequeue on a full queue
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b0, 8'(i * 8'h11), 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
      checkOutput("both_ack",  32'(ack_in), 32'd1);
      checkOutput("both_dv",   32'(deq_valid), 32'd1);
      checkOutput("both_len",  32'(len_out), 32'd8);
      checkOutput("both_data", 32'(data_out), 32'h11);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("both_drain", 32'(data_out), (i < 7) ? 32'((i + 2) * 8'h11) : 32'h99);
      end

      // Interleaved traffic at depth 3 across several pointer wraps
      for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
         checkOutput("wrap_data", 32'(data_out), (i < 3) ? 32'(i + 1) : 32'(8'h40 + i - 3));
         checkOutput("wrap_len",  32'(len_out), 32'd3);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
         checkOutput("wrap_tail", 32'(data_out), 32'(8'h51 + i));
      end
      checkOutput("wrap_errs", 32'({overflow, underflow}), 32'd0);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
      checkOutput("mid_len", 32'(len_out), 32'd5);
      #10 reset = 1'b1;
      #1;
      checkOutput("mid_rst_len",   32'(len_out), 32'd0);
      checkOutput("mid_rst_empty", 32'(empty), 32'd1);
      checkOutput("mid_rst_data",  32'(data_out), 32'd0);
      checkOutput("mid_rst_fwft",  32'(f_data_out), 32'd0);
      @(negedge clk_10khz);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      checkOutput("post_rst_data",  32'(data_out), 32'hA5);
      checkOutput("post_rst_empty", 32'(empty), 32'd1);

      // First-word-fall-through visibility and clear vs. new overflow
      applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0);
      checkOutput("fwft_head", 32'(f_data_out), 32'h3C);
      checkOutput("reg_hold",  32'(data_out), 32'hA5);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
      applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
      checkOutput("clr_vs_set",   32'(overflow), 32'd1);
      checkOutput("clr_vs_set_f", 32'(f_overflow), 32'd1);
      checkOutput("fwft_full_hd", 32'(f_data_out), 32'h3C);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("final_clear", 32'(overflow), 32'd0);

      @(negedge clk_10khz);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/param_queue.md
PARAM_QUEUE -- requirements
Module: param_queue

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (1..32).
REQ-002 Parameter DEPTH, default 8, queue capacity in words; power of two, 2..256.
REQ-003 Parameter AFULL_TH, default DEPTH-1, count at or above which almost_full asserts.
REQ-004 Parameter AEMPTY_TH, default 1, count at or below which almost_empty asserts.
REQ-005 Parameter FWFT, default 0; 0 = registered pop output, 1 = first-word-fall-through.
REQ-006 clk_10khz  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 data_in  input  DATA_W  word to enqueue.
REQ-009 enqueue_in  input  1  enqueue request, sampled each clock edge.
REQ-010 dequeue_in  input  1  dequeue request, sampled each clock edge.
REQ-011 clear_flags  input  1  clears sticky overflow/underflow.
REQ-012 ack_in  output  1  registered pulse: enqueue accepted on previous edge.
REQ-013 deq_valid  output  1  registered pulse: dequeue accepted on previous edge.
REQ-014 data_out  output  DATA_W  dequeued word (FWFT=0) or current head (FWFT=1).
REQ-015 len_out  output  $clog2(DEPTH+1)  current word count, 0..DEPTH.
REQ-016 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Storage SHALL be a DEPTH-entry circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0; no data shifting.
REQ-019 Dequeue SHALL be accepted when dequeue_in=1 and count>0; rd_ptr advances, count decrements.
REQ-020 Enqueue SHALL be accepted when enqueue_in=1 and (count<DEPTH or a dequeue is accepted the same edge); data_in written at wr_ptr, wr_ptr advances.
REQ-021 Simultaneous accepted enqueue+dequeue: count unchanged, at any occupancy including full; at empty only the enqueue is accepted (no bypass).
REQ-022 ack_in SHALL be 1 for exactly the cycle following each accepted enqueue, else 0; deq_valid likewise for dequeue.
REQ-023 FWFT=0: data_out SHALL load the head word on the edge a dequeue is accepted and hold otherwise (latency 1 cycle, aligned with deq_valid).
REQ-024 FWFT=1: data_out SHALL combinationally show mem[rd_ptr] when count>0, all zeros when empty.
REQ-025 full = (count==DEPTH); empty = (count==0); almost_full = (count>=AFULL_TH); almost_empty = (count<=AEMPTY_TH); all derived combinationally from count.
REQ-026 overflow SHALL set on an edge where enqueue_in=1 is rejected; underflow on an edge where dequeue_in=1 with count==0.
REQ-027 clear_flags=1 SHALL clear both sticky flags on the edge; a set condition on the same edge wins.
REQ-028 len_out SHALL equal count; count never exceeds DEPTH nor underflows 0.

Reset
REQ-029 reset=1 SHALL immediately force count, pointers, ack_in, deq_valid, data_out (FWFT=0), overflow, underflow to 0; empty=1, almost_empty=1, full=0.
REQ-030 Storage contents need not be cleared; reset mid-operation SHALL discard all queued words.

Structure
REQ-031 Shared package queue_pkg SHALL hold default DATA_W/DEPTH constants and the ptr/count width helper function.
REQ-032 One sub-module queue_ptr (wrapping pointer counter with enable) SHALL be instantiated for wr_ptr and rd_ptr.

Verification
REQ-033 DEPTH=8: enqueue 0x11..0x88 -> ack_in 8 pulses, full=1, len_out=8; 9th enqueue -> no ack, overflow=1.
REQ-034 Dequeue 8 times after REQ-033 -> data_out 0x11..0x88 in order one cycle after each request, empty=1; 9th -> underflow=1.
REQ-035 Full queue, enqueue 0x99 + dequeue same cycle -> both accepted, len_out stays 8, data_out=0x11, 0x99 emerges last.
REQ-036 Enqueue/dequeue 20 words interleaved at depth 3 -> pointer wrap, order preserved, no flag errors.
REQ-037 Assert reset with len_out=5 mid-burst -> all outputs per REQ-029 within same cycle; next enqueue of 0xA5 then dequeue returns 0xA5.
REQ-038 FWFT=1, enqueue 0x3C -> data_out=0x3C next cycle without dequeue; clear_flags with pending overflow set -> overflow=1 retained.
